uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receive front end feeding `riscv_top` from its `Rx` pin. Synchronises the asynchronous line and deserialises 8N1 UART frames by mid-bit sampling. Buffers received bytes in a small FIFO that the host-communication logic drains. It is the stage directly downstream of the bench/board driver that toggles `Rx`.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per bit; ≥ 4. Simulation benches set it to 16.
- `FIFO_DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `rx`  in  1  raw serial line; idle high; asynchronous.
- `rd_en`  in  1  pop the head byte; ignored when `empty` = 1.
- `err_clr`  in  1  clears the sticky error flags.
- `rd_data`  out  8  head byte (show-ahead); valid while `empty` = 0.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `overrun`  out  1  sticky; a byte arrived while the FIFO was full.
- `parity_err`  out  1  sticky; parity mismatch. Tied to 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- The 2-FF synchroniser on `rx` resets to 1. All FSM decisions use the synchronised bit, `rxs`.
- The FSM has states IDLE, START, DATA, (PARITY), STOP. A bit counter (0..CLKS_PER_BIT-1) and a data index (0..7) run alongside it.
- IDLE: when `rxs` = 0, clear the bit counter and go to START.
- START: at count CLKS_PER_BIT/2-1 (integer divide):
  - `rxs` = 0: clear the counter and go to DATA.
  - `rxs` = 1: treat as a glitch and return to IDLE; no flag is set.
- DATA: sample at every count of CLKS_PER_BIT-1, shifting LSB first into the shift register. After index 7, go to PARITY (if compiled in) or STOP.
- STOP: sample at CLKS_PER_BIT-1.
  - `rxs` = 1: push the byte into the FIFO.
  - `rxs` = 0: set `frame_err` and discard the byte.
  - Either way, go to IDLE. The FSM does not wait for the line to return high; a low line restarts START on the next cycle.
- Push when the FIFO is full:
  - without a same-cycle pop: the byte is dropped and `overrun` is set;
  - with a same-cycle pop (`rd_en`): the push is accepted and `overrun` is not set.
- Pop with `rd_en` = 1 while `empty` = 1 has no effect and no flag.
- `err_clr` clears all sticky flags. An error event in the same cycle wins: the flag stays set.
- Reset values: FSM in IDLE, pointers and count at 0, `empty` = 1, `full` = 0, all error flags 0, `rd_data` = 0.
- Reset asserted mid-frame aborts the frame, and FIFO contents are lost.

## Timing
- A falling edge on `rx` reaches `rxs` 2 cycles later.
- The stop sample occurs at 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after that edge (plus CLKS_PER_BIT with parity).
- `empty` falls, and `rd_data` is valid, on the cycle after the stop sample.
- Pop: `rd_data` shows the next entry and `empty`/`full` update on the cycle after the `rd_en` edge.
- Error flags rise on the cycle after the offending sample.
- Throughput: back-to-back frames with zero idle bits are received without loss while the FIFO is not full.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: the PARITY state sits between DATA and STOP and samples one even-parity bit.
  - On mismatch, set `parity_err`; the byte is discarded at STOP regardless of the stop bit.
  - If the stop bit is also low, `frame_err` is set too.
- Undefined: the PARITY state is not built, frames are 8N1, and `parity_err` is constant 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum;
  - `UART_DATA_BITS` = 8;
  - helper function computing CLKS_PER_BIT from clock and baud (used by top-level parameters).
- Sub-module `sync_fifo`, parameterised by width and depth:
  - ports `push`, `wdata`, `pop`, `rdata`, `empty`, `full`;
  - implements the pointer/count logic and same-cycle push/pop rules above.
- The receive FSM, synchroniser and error flags stay in `uart_rx_fifo`.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- Reset, then send 0xA5 → `empty` falls exactly 2+8+144 cycles after the start edge; `rd_data` = 0xA5; no flags set.
- Send 0x00, 0xFF, 0x3C back-to-back with zero idle, then pop three times → bytes read in order 0x00, 0xFF, 0x3C; `empty` returns to 1.
- 4-cycle low glitch on idle `rx` → the FSM returns to IDLE; FIFO stays empty; no flags set.
- Send 0x55 with the stop bit held low → `frame_err` = 1 and the FIFO stays empty. Then pulse `err_clr` → `frame_err` = 0.
- Send 9 bytes (depth 8) without popping → the first 8 are stored, `full` = 1, `overrun` = 1, and the 9th is lost. Repeat with `rd_en` asserted on the 9th byte's push cycle → `overrun` stays 0.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → `parity_err` = 1 and the byte is discarded. Send with parity bit 1 → 0x07 is stored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, frame width and the
// clock/baud helper used to size the bit timer.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Rounded to the nearest whole clock so the mid-bit sample drifts least.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle. DEPTH must be a power of two.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_wr;
  logic              w_rd;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign w_rd  = pop && !empty;
  assign w_wr  = push && (!full || w_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wdata;
  end

  // Stale storage is masked so the head reads as zero whenever nothing is held.
  assign rdata = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 2-FF input synchroniser, sticky error flags and a
// byte FIFO. Define UART_RX_PARITY_EN to add an even-parity bit (8E1).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = calc_clks_per_bit(100_000_000, 115_200),
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      rd_en,
  input  logic                      err_clr,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      empty,
  output logic                      full,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               r_state;
  uart_state_e               w_next;
  logic                      r_sync1;
  logic                      r_sync2;
  logic                      w_rxs;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      w_cnt_last;
  logic                      w_cnt_clr;
  logic                      w_shift;
  logic                      w_push;
  logic                      w_frame_set;
  logic                      w_ovr_set;
  logic                      w_par_bad;
  logic                      w_empty;
  logic                      w_full;
  logic                      r_frame_err;
  logic                      r_overrun;
`ifdef UART_RX_PARITY_EN
  logic                      w_par_set;
  logic                      r_par_bad;
  logic                      r_parity_err;
`endif

  // Idle-high reset value keeps a reset release from looking like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rxs = r_sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_next      = r_state;
    w_cnt_clr   = 1'b0;
    w_shift     = 1'b0;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_set   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_rxs) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_START;
        end
      end
      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_clr = 1'b1;
          w_next    = w_rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_cnt_last) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_next = ST_PARITY;
`else
            w_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_cnt_last) begin
          w_cnt_clr = 1'b1;
          w_par_set = (w_rxs != ^r_shift);
          w_next    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Back to IDLE straight away: a still-low line simply re-arms START.
        if (w_cnt_last) begin
          w_cnt_clr   = 1'b1;
          w_push      = w_rxs && !w_par_bad;
          w_frame_set = !w_rxs;
          w_next      = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (r_state == ST_IDLE) r_idx <= '0;
      else if (w_shift)       r_idx <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_shift) r_shift <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                  r_par_bad <= 1'b0;
    else if (r_state == ST_IDLE) r_par_bad <= 1'b0;
    else if (w_par_set)          r_par_bad <= 1'b1;
  end
  assign w_par_bad = r_par_bad;

  always_ff @(posedge clk) begin
    if (!rst_n)         r_parity_err <= 1'b0;
    else if (w_par_set) r_parity_err <= 1'b1;
    else if (err_clr)   r_parity_err <= 1'b0;
  end
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  // A same-cycle pop frees the slot, so only an unpaired full push overruns.
  assign w_ovr_set = w_push && w_full && !rd_en;

  // A new error event outranks err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_set)  r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
      if (w_ovr_set)    r_overrun   <= 1'b1;
      else if (err_clr) r_overrun   <= 1'b0;
    end
  end
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  sync_fifo #(
    .DATA_W (UART_DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (r_shift),
    .pop   (rd_en),
    .rdata (rd_data),
    .empty (w_empty),
    .full  (w_full)
  );

  assign empty = w_empty;
  assign full  = w_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 16 clocks per bit, depth 8; covers the
// parity scenarios too when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Cycles from the first clock edge that sees rx low to the edge that pushes.
  localparam int STOP_LAT = 2 + CPB / 2 + (NBITS - 1) * CPB;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx      = 1'b1;
  logic       rd_en   = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] sb [$];

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All stimulus changes land 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp;
    int w;
    w = 0;
    while (empty && w < 400) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, rd_data=%02h empty=%b", name, rd_data, empty);
    end else begin
      exp = sb.pop_front();
      if (empty !== 1'b0 || rd_data !== exp) begin
        n_miss++;
        $display("FAIL %s: got rd_data=%02h empty=%b, expected rd_data=%02h empty=0",
                 name, rd_data, empty, exp);
      end
    end
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic clear_errors;
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(4);
    rst_n = 1'b1;
    idle(1);
    n_vec++;
    if ({empty, full, frame_err, overrun, parity_err} !== 5'b10000) begin
      n_miss++;
      $display("FAIL reset_flags: got {empty,full,fe,ov,pe}=%b, expected 10000",
               {empty, full, frame_err, overrun, parity_err});
    end
    n_vec++;
    if (rd_data !== 8'h00) begin
      n_miss++;
      $display("FAIL reset_rd_data: got %02h, expected 00", rd_data);
    end
  endtask

  task automatic test_latency;
    int lat;
    lat = -1;
    sb.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int c = 0; c < 400; c++) begin
          @(posedge clk);
          #2;
          if (!empty) begin
            lat = c;
            break;
          end
        end
      end
    join
    n_vec++;
    if (lat != STOP_LAT) begin
      n_miss++;
      $display("FAIL latency: empty fell after %0d cycles, expected %0d", lat, STOP_LAT);
    end
    n_vec++;
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      n_miss++;
      $display("FAIL latency_flags: got {fe,ov,pe}=%b, expected 000",
               {frame_err, overrun, parity_err});
    end
    pop_check("latency_data");
    n_vec++;
    if (empty !== 1'b1) begin
      n_miss++;
      $display("FAIL latency_drain: got empty=%b, expected 1", empty);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat [3];
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(pat[i]);
      send_frame(pat[i], 1'b1);
    end
    for (int i = 0; i < 3; i++) pop_check("b2b_data");
    n_vec++;
    if (empty !== 1'b1 || frame_err !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_end: got empty=%b fe=%b, expected empty=1 fe=0", empty, frame_err);
    end
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * CPB);
    n_vec++;
    if ({empty, frame_err, overrun, parity_err} !== 4'b1000) begin
      n_miss++;
      $display("FAIL glitch: got {empty,fe,ov,pe}=%b, expected 1000",
               {empty, frame_err, overrun, parity_err});
    end
  endtask

  task automatic test_frame_error;
    send_frame(8'h55, 1'b0);
    idle(2 * CPB);
    n_vec++;
    if ({empty, frame_err} !== 2'b11) begin
      n_miss++;
      $display("FAIL frame_err_set: got {empty,fe}=%b, expected 11", {empty, frame_err});
    end
    clear_errors();
    n_vec++;
    if (frame_err !== 1'b0) begin
      n_miss++;
      $display("FAIL frame_err_clr: got fe=%b, expected 0", frame_err);
    end
  endtask

  task automatic fill_fifo;
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      sb.push_back(b);
      send_frame(b, 1'b1);
    end
    n_vec++;
    if ({full, overrun} !== 2'b10) begin
      n_miss++;
      $display("FAIL fill: got {full,ov}=%b, expected 10", {full, overrun});
    end
  endtask

  task automatic test_overrun;
    logic [7:0] exp;
    fill_fifo();
    send_frame(8'hE7, 1'b1);
    n_vec++;
    if ({full, overrun} !== 2'b11) begin
      n_miss++;
      $display("FAIL overrun_set: got {full,ov}=%b, expected 11", {full, overrun});
    end
    for (int i = 0; i < DEPTH; i++) pop_check("overrun_data");
    n_vec++;
    if (empty !== 1'b1) begin
      n_miss++;
      $display("FAIL overrun_lost: got empty=%b rd_data=%02h, expected empty=1", empty, rd_data);
    end
    clear_errors();
    n_vec++;
    if (overrun !== 1'b0) begin
      n_miss++;
      $display("FAIL overrun_clr: got ov=%b, expected 0", overrun);
    end

    // Refill, then pop the head on the exact edge that pushes the 9th byte.
    fill_fifo();
    sb.push_back(8'h9B);
    fork
      send_frame(8'h9B, 1'b1);
      begin
        @(posedge clk);
        repeat (STOP_LAT - 1) @(posedge clk);
        #1;
        exp = sb.pop_front();
        n_vec++;
        if (rd_data !== exp) begin
          n_miss++;
          $display("FAIL same_cycle_head: got %02h, expected %02h", rd_data, exp);
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
      end
    join
    n_vec++;
    if ({full, overrun} !== 2'b10) begin
      n_miss++;
      $display("FAIL same_cycle_pop: got {full,ov}=%b, expected 10", {full, overrun});
    end
    for (int i = 0; i < DEPTH; i++) pop_check("same_cycle_data");
    n_vec++;
    if (empty !== 1'b1) begin
      n_miss++;
      $display("FAIL same_cycle_drain: got empty=%b, expected 1", empty);
    end
  endtask

  task automatic test_reset_midframe;
    send_frame(8'h5A, 1'b1);
    n_vec++;
    if (empty !== 1'b0) begin
      n_miss++;
      $display("FAIL midframe_stored: got empty=%b, expected 0", empty);
    end
    rx = 1'b0;
    idle(3 * CPB);
    rst_n = 1'b0;
    rx = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(12 * CPB);
    n_vec++;
    if ({empty, frame_err, rd_data} !== {2'b10, 8'h00}) begin
      n_miss++;
      $display("FAIL midframe_reset: got empty=%b fe=%b rd_data=%02h, expected 1 0 00",
               empty, frame_err, rd_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'h07 >> i);
    send_bit(1'b0);
    send_bit(1'b1);
    idle(CPB);
    n_vec++;
    if ({parity_err, empty} !== 2'b11) begin
      n_miss++;
      $display("FAIL parity_bad: got {pe,empty}=%b, expected 11", {parity_err, empty});
    end
    clear_errors();
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    n_vec++;
    if (parity_err !== 1'b0) begin
      n_miss++;
      $display("FAIL parity_good_flag: got pe=%b, expected 0", parity_err);
    end
    pop_check("parity_good_data");
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
